cpu_stall_core: RTL and testbench
=================================

Name: cpu_stall_core

Overview:
- Parametrised successor of the group's single-cycle 8-bit CPU.
- DATA_WIDTH-wide datapath, REG_COUNT-entry register file, 32-bit instructions, combinational ALU path.
- Adds a handshaked data-memory port (load/store) and instruction-fetch stalling. A two-state controller freezes PC and register writes while either memory reports busy.
- Sits between the instruction memory/cache and the data memory/cache in the top-level testbench.

Parameters:
DATA_WIDTH, 8, width of registers, ALU, data-memory address and data
REG_COUNT, 8, number of registers; power of two, 2..256

Ports:
CLK  input  1  system clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
INSTRUCTION  input  32  instruction at PC; valid when INSTR_BUSYWAIT=0
INSTR_BUSYWAIT  input  1  1 = instruction not yet valid; stall
PC  output  32  address of current instruction
MEM_READ  output  1  data-memory read request
MEM_WRITE  output  1  data-memory write request
MEM_ADDRESS  output  DATA_WIDTH  data-memory address
MEM_WRITEDATA  output  DATA_WIDTH  store data
MEM_READDATA  input  DATA_WIDTH  load data; valid in the cycle MEM_BUSYWAIT=0
MEM_BUSYWAIT  input  1  1 = memory transaction in progress

Behaviour:
- Instruction fields:
  - OP=[31:24]
  - RD/OFFSET=[23:16]
  - RS1=[15:8]
  - RS2/IMM=[7:0]
  - Register indices use the low log2(REG_COUNT) bits.
  - IMM and OFFSET are sign-extended.
- Opcodes:
  - 0 loadi: RD<=IMM
  - 1 mov: RD<=R[RS2]
  - 2 add: RD<=R[RS1]+R[RS2]
  - 3 sub: RD<=R[RS1]-R[RS2]
  - 4 and: RD<=R[RS1]&R[RS2]
  - 5 or: RD<=R[RS1]|R[RS2]
  - 6 j: PC<=PC+4+(OFFSET<<2)
  - 7 beq: branch if R[RS1]==R[RS2]
  - 8 lwd: RD<=M[R[RS2]]
  - 9 lwi: RD<=M[IMM]
  - 10 swd: M[R[RS2]]<=R[RS1]
  - 11 swi: M[IMM]<=R[RS1]
  - 12 bne: branch if R[RS1]!=R[RS2]
  - Any other opcode: no-op, PC<=PC+4.
- Arithmetic is modulo 2^DATA_WIDTH. Branch/jump target arithmetic is 32-bit, wraps at 2^32.
- Reset:
  - PC=0 and all registers=0.
  - State=EXEC; MEM_READ=MEM_WRITE=0; MEM_ADDRESS=MEM_WRITEDATA=0.
  - Reset wins over every other event. A RESET mid-transaction drops MEM_READ/MEM_WRITE on the next edge and discards the load.
- State EXEC:
  - INSTR_BUSYWAIT=1: no PC or register update; stay in EXEC.
  - Non-memory opcode: register write and PC update on the same edge. Latency is 1 cycle per instruction.
  - Load/store opcode: register MEM_ADDRESS; register MEM_WRITEDATA (stores); assert MEM_READ or MEM_WRITE; go to MEM_WAIT. PC is held.
- State MEM_WAIT:
  - Request outputs are held stable.
  - MEM_BUSYWAIT=1: stay.
  - MEM_BUSYWAIT=0 at an edge:
    - load: RD<=MEM_READDATA
    - PC<=PC+4
    - MEM_READ/MEM_WRITE<=0
    - return to EXEC
  - Minimum load/store cost is 2 cycles.
- MEM_READ and MEM_WRITE are never both 1. Neither is 1 outside MEM_WAIT.
- Register reads are combinational. A write to RD is visible to the next instruction with no hazard, since there is one instruction in flight.
- Writes to any register, including R0, are allowed; nothing is hardwired.
- MEM_BUSYWAIT while in EXEC is ignored.
- INSTR_BUSYWAIT while in MEM_WAIT is ignored (the instruction is already latched).

Test Plan:
- ALU sequence, DATA_WIDTH=8, no stalls:
  - Stimulus: loadi r1,5; loadi r2,0xFD; add r3,r1,r2; sub r4,r1,r2.
  - Required: r3=0x02, r4=0x08; PC=0,4,8,12,16 on consecutive cycles.
- Branches and jump:
  - beq with r1==r2 and OFFSET=0xFE → PC goes from 8 to 4.
  - bne with equal regs → PC+4.
  - j with OFFSET=3 at PC=0 → PC=16.
- Load with stall:
  - Stimulus: lwd r5,r1 with r1=0x20; MEM_BUSYWAIT=1 for 3 cycles, then 0 with MEM_READDATA=0xA7.
  - Required: MEM_READ=1, MEM_ADDRESS=0x20 stable throughout; r5=0xA7 and PC+4 on the release edge; MEM_READ=0 afterwards.
- Store:
  - Stimulus: swi r1,0x40 with r1=0x5C.
  - Required: MEM_WRITE=1, MEM_ADDRESS=0x40, MEM_WRITEDATA=0x5C; MEM_READ=0; no register changes.
- Instruction stall:
  - Stimulus: INSTR_BUSYWAIT=1 for 2 cycles mid-program.
  - Required: PC and registers frozen; execution resumes without skipping.
- Reset mid-load and width:
  - RESET asserted during MEM_WAIT → next edge PC=0, MEM_READ=0, all regs 0, RD not written.
  - Repeat the ALU test with DATA_WIDTH=16, REG_COUNT=16: loadi r15,0x80 → r15=0xFF80.

Source files
------------

// File: rtl/cpu_stall_core.sv
// cpu_stall_core: parametrised single-issue CPU with stalling
// instruction fetch and a handshaked data-memory port.
module cpu_stall_core #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_COUNT  = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           INSTRUCTION,
  input  logic                  INSTR_BUSYWAIT,
  output logic [31:0]           PC,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [DATA_WIDTH-1:0] MEM_ADDRESS,
  output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [DATA_WIDTH-1:0] MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  localparam int IW = $clog2(REG_COUNT);

  localparam logic [0:0] S_EXEC     = 1'b0;
  localparam logic [0:0] S_MEM_WAIT = 1'b1;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_LWD   = 8'd8;
  localparam logic [7:0] OP_LWI   = 8'd9;
  localparam logic [7:0] OP_SWD   = 8'd10;
  localparam logic [7:0] OP_SWI   = 8'd11;
  localparam logic [7:0] OP_BNE   = 8'd12;

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic                  ld_q;
  logic [IW-1:0]         ld_rd;

  logic [7:0]            op;
  logic [IW-1:0]         rd;
  logic [IW-1:0]         rs1;
  logic [IW-1:0]         rs2;
  logic signed [7:0]     imm_s;
  logic signed [7:0]     off_s;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [31:0]           off_ext;
  logic [31:0]           pc_4;
  logic [31:0]           pc_br;
  logic                  unused_bits;

  assign op      = INSTRUCTION[31:24];
  assign rd      = INSTRUCTION[16 +: IW];
  assign rs1     = INSTRUCTION[8 +: IW];
  assign rs2     = INSTRUCTION[0 +: IW];
  assign imm_s   = INSTRUCTION[7:0];
  assign off_s   = INSTRUCTION[23:16];
  assign imm_ext = DATA_WIDTH'(imm_s);
  assign off_ext = 32'(off_s);
  assign a       = regs[rs1];
  assign b       = regs[rs2];
  assign pc_4    = PC + 32'd4;
  assign pc_br   = pc_4 + {off_ext[29:0], 2'b00};

  // only the low index bits of each field are decoded
  assign unused_bits = ^INSTRUCTION[23:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      PC            <= '0;
      state         <= S_EXEC;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      ld_q          <= 1'b0;
      ld_rd         <= '0;
      for (int i = 0; i < REG_COUNT; i++)
        regs[i] <= '0;
    end else begin
      unique case (state)
        S_EXEC: if (!INSTR_BUSYWAIT) begin
          unique case (op)
            OP_LOADI: begin
              regs[rd] <= imm_ext;
              PC       <= pc_4;
            end
            OP_MOV: begin
              regs[rd] <= b;
              PC       <= pc_4;
            end
            OP_ADD: begin
              regs[rd] <= a + b;
              PC       <= pc_4;
            end
            OP_SUB: begin
              regs[rd] <= a - b;
              PC       <= pc_4;
            end
            OP_AND: begin
              regs[rd] <= a & b;
              PC       <= pc_4;
            end
            OP_OR: begin
              regs[rd] <= a | b;
              PC       <= pc_4;
            end
            OP_J:   PC <= pc_br;
            OP_BEQ: PC <= (a == b) ? pc_br : pc_4;
            OP_BNE: PC <= (a != b) ? pc_br : pc_4;
            OP_LWD: begin
              MEM_ADDRESS <= b;
              MEM_READ    <= 1'b1;
              ld_q        <= 1'b1;
              ld_rd       <= rd;
              state       <= S_MEM_WAIT;
            end
            OP_LWI: begin
              MEM_ADDRESS <= imm_ext;
              MEM_READ    <= 1'b1;
              ld_q        <= 1'b1;
              ld_rd       <= rd;
              state       <= S_MEM_WAIT;
            end
            OP_SWD: begin
              MEM_ADDRESS   <= b;
              MEM_WRITEDATA <= a;
              MEM_WRITE     <= 1'b1;
              ld_q          <= 1'b0;
              state         <= S_MEM_WAIT;
            end
            OP_SWI: begin
              MEM_ADDRESS   <= imm_ext;
              MEM_WRITEDATA <= a;
              MEM_WRITE     <= 1'b1;
              ld_q          <= 1'b0;
              state         <= S_MEM_WAIT;
            end
            default: PC <= pc_4;
          endcase
        end
        S_MEM_WAIT: if (!MEM_BUSYWAIT) begin
          // destination was latched at issue; INSTRUCTION may move
          if (ld_q)
            regs[ld_rd] <= MEM_READDATA;
          PC        <= pc_4;
          MEM_READ  <= 1'b0;
          MEM_WRITE <= 1'b0;
          state     <= S_EXEC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_stall_core.sv
// tb_cpu_stall_core: directed vector bench for cpu_stall_core
// at 8-bit/8-reg and 16-bit/16-reg configurations.
module tb_cpu_stall_core;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst8, ib8, mr8, mw8, mb8;
  logic [31:0] ins8, pc8;
  logic [7:0]  ma8, wd8, rdat8;

  logic        rst16, ib16, mr16, mw16, mb16;
  logic [31:0] ins16, pc16;
  logic [15:0] ma16, wd16, rdat16;

  cpu_stall_core #(.DATA_WIDTH(8), .REG_COUNT(8)) dut8 (
    .CLK(CLK), .RESET(rst8), .INSTRUCTION(ins8),
    .INSTR_BUSYWAIT(ib8), .PC(pc8), .MEM_READ(mr8),
    .MEM_WRITE(mw8), .MEM_ADDRESS(ma8),
    .MEM_WRITEDATA(wd8), .MEM_READDATA(rdat8),
    .MEM_BUSYWAIT(mb8)
  );

  cpu_stall_core #(.DATA_WIDTH(16), .REG_COUNT(16)) dut16 (
    .CLK(CLK), .RESET(rst16), .INSTRUCTION(ins16),
    .INSTR_BUSYWAIT(ib16), .PC(pc16), .MEM_READ(mr16),
    .MEM_WRITE(mw16), .MEM_ADDRESS(ma16),
    .MEM_WRITEDATA(wd16), .MEM_READDATA(rdat16),
    .MEM_BUSYWAIT(mb16)
  );

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        ib;
    logic        mb;
    logic [15:0] rdata;
    logic [31:0] pc;
    logic        rd;
    logic        wr;
    logic        ca;
    logic [15:0] addr;
    logic        cw;
    logic [15:0] wd;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl8[$];
  vec_t tbl16[$];

  localparam logic [31:0] NOP_I = 32'h0001_0077;

  function automatic logic [31:0] enc(int op, int d, int s1, int s2);
    return {op[7:0], d[7:0], s1[7:0], s2[7:0]};
  endfunction

  function automatic vec_t mk(logic rst, logic [31:0] ins,
      logic ib, logic mb, logic [15:0] rdata, logic [31:0] pc,
      logic rd, logic wr, logic ca, logic [15:0] addr,
      logic cw, logic [15:0] wd);
    vec_t v;
    v.rst = rst; v.ins = ins; v.ib = ib; v.mb = mb;
    v.rdata = rdata; v.pc = pc; v.rd = rd; v.wr = wr;
    v.ca = ca; v.addr = addr; v.cw = cw; v.wd = wd;
    return v;
  endfunction

  function automatic vec_t rs();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
  endfunction
  function automatic vec_t ex(logic [31:0] ins, logic [31:0] pc);
    return mk(0, ins, 0, 0, 0, pc, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic vec_t stall(logic [31:0] ins, logic [31:0] pc);
    return mk(0, ins, 1, 0, 0, pc, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic vec_t sw(logic [31:0] ins, logic mb,
      logic [31:0] pc, logic [15:0] addr, logic [15:0] wd);
    return mk(0, ins, 0, mb, 0, pc, 0, 1, 1, addr, 1, wd);
  endfunction
  function automatic vec_t ld(logic [31:0] ins, logic mb,
      logic [31:0] pc, logic [15:0] addr);
    return mk(0, ins, 0, mb, 16'h11, pc, 1, 0, 1, addr, 0, 0);
  endfunction
  function automatic vec_t hold(logic [31:0] pc, logic rd,
      logic wr, logic [15:0] addr);
    return mk(0, NOP_I, 0, 1, 16'h11, pc, rd, wr, 1, addr, 0, 0);
  endfunction
  function automatic vec_t rel(logic [31:0] pc, logic [15:0] rdata);
    return mk(0, NOP_I, 1, 0, rdata, pc, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(string tag, int idx, string nm,
      logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] %s: got %h want %h",
               tag, idx, nm, act, exp);
    end
  endtask

  task automatic run(vec_t v, bit wide, string tag, int idx);
    logic [31:0] pc;
    logic        r, w;
    logic [15:0] a, d;
    if (wide) begin
      rst16 = v.rst; ins16 = v.ins; ib16 = v.ib;
      mb16 = v.mb; rdat16 = v.rdata;
    end else begin
      rst8 = v.rst; ins8 = v.ins; ib8 = v.ib;
      mb8 = v.mb; rdat8 = v.rdata[7:0];
    end
    @(posedge CLK);
    #1;
    if (wide) begin
      pc = pc16; r = mr16; w = mw16; a = ma16; d = wd16;
    end else begin
      pc = pc8; r = mr8; w = mw8;
      a = {8'h00, ma8}; d = {8'h00, wd8};
    end
    chk(tag, idx, "pc", pc, v.pc);
    chk(tag, idx, "mem_read", 32'(r), 32'(v.rd));
    chk(tag, idx, "mem_write", 32'(w), 32'(v.wr));
    if (v.ca) chk(tag, idx, "mem_addr", 32'(a), 32'(v.addr));
    if (v.cw) chk(tag, idx, "mem_wdata", 32'(d), 32'(v.wd));
  endtask

  initial begin
    rst8 = 1; ins8 = 0; ib8 = 0; mb8 = 0; rdat8 = 0;
    rst16 = 1; ins16 = 0; ib16 = 0; mb16 = 0; rdat16 = 0;

    // ALU, stores, loads, stalls, branches on the 8-bit core
    tbl8.push_back(rs());
    tbl8.push_back(ex(enc(0, 1, 0, 5), 4));
    tbl8.push_back(ex(enc(0, 2, 0, 8'hFD), 8));
    tbl8.push_back(ex(enc(2, 3, 1, 2), 12));
    tbl8.push_back(ex(enc(3, 4, 1, 2), 16));
    tbl8.push_back(sw(enc(11, 0, 3, 8'h40), 1, 16, 16'h40, 16'h02));
    tbl8.push_back(rel(20, 0));
    tbl8.push_back(sw(enc(11, 0, 4, 8'h41), 0, 20, 16'h41, 16'h08));
    tbl8.push_back(rel(24, 0));
    tbl8.push_back(ex(enc(0, 1, 0, 8'h5C), 28));
    tbl8.push_back(sw(enc(11, 0, 1, 8'h40), 1, 28, 16'h40, 16'h5C));
    tbl8.push_back(mk(0, NOP_I, 0, 1, 0, 28, 0, 1, 1, 16'h40, 1, 16'h5C));
    tbl8.push_back(rel(32, 0));
    tbl8.push_back(ex(enc(0, 1, 0, 8'h20), 36));
    tbl8.push_back(ld(enc(8, 5, 0, 1), 1, 36, 16'h20));
    tbl8.push_back(hold(36, 1, 0, 16'h20));
    tbl8.push_back(hold(36, 1, 0, 16'h20));
    tbl8.push_back(hold(36, 1, 0, 16'h20));
    tbl8.push_back(rel(40, 16'hA7));
    tbl8.push_back(sw(enc(11, 0, 5, 0), 0, 40, 16'h00, 16'hA7));
    tbl8.push_back(rel(44, 0));
    tbl8.push_back(stall(enc(0, 5, 0, 8'h33), 44));
    tbl8.push_back(stall(enc(0, 5, 0, 8'h33), 44));
    tbl8.push_back(ex(enc(0, 6, 0, 8'h33), 48));
    tbl8.push_back(sw(enc(11, 0, 5, 1), 0, 48, 16'h01, 16'hA7));
    tbl8.push_back(rel(52, 0));
    tbl8.push_back(ex(enc(4, 7, 5, 6), 56));
    tbl8.push_back(ex(enc(5, 0, 5, 6), 60));
    tbl8.push_back(ex(enc(1, 2, 0, 0), 64));
    tbl8.push_back(sw(enc(11, 0, 7, 2), 0, 64, 16'h02, 16'h23));
    tbl8.push_back(rel(68, 0));
    tbl8.push_back(sw(enc(11, 0, 2, 3), 0, 68, 16'h03, 16'hB7));
    tbl8.push_back(rel(72, 0));
    tbl8.push_back(ld(enc(9, 3, 0, 8'h90), 0, 72, 16'h90));
    tbl8.push_back(rel(76, 16'h3C));
    tbl8.push_back(sw(enc(11, 0, 3, 4), 0, 76, 16'h04, 16'h3C));
    tbl8.push_back(rel(80, 0));
    tbl8.push_back(rs());
    tbl8.push_back(sw(enc(11, 0, 4, 0), 0, 0, 16'h00, 16'h00));
    tbl8.push_back(rel(4, 0));
    tbl8.push_back(rs());
    tbl8.push_back(ex(enc(6, 3, 0, 0), 16));
    tbl8.push_back(rs());
    tbl8.push_back(ex(enc(0, 1, 0, 7), 4));
    tbl8.push_back(ex(enc(0, 2, 0, 7), 8));
    tbl8.push_back(ex(enc(7, 8'hFE, 1, 2), 4));
    tbl8.push_back(ex(enc(12, 5, 1, 2), 8));
    tbl8.push_back(ex(enc(0, 2, 0, 8), 12));
    tbl8.push_back(ex(enc(7, 5, 1, 2), 16));
    tbl8.push_back(ex(enc(12, 8'hFF, 1, 2), 16));
    tbl8.push_back(ex(enc(8'hEE, 1, 2, 3), 20));

    // 16-bit datapath, 16 registers
    tbl16.push_back(rs());
    tbl16.push_back(ex(enc(0, 15, 0, 8'h80), 4));
    tbl16.push_back(sw(enc(11, 0, 15, 8'h10), 0, 4, 16'h10, 16'hFF80));
    tbl16.push_back(rel(8, 0));
    tbl16.push_back(ex(enc(0, 1, 0, 5), 12));
    tbl16.push_back(ex(enc(0, 2, 0, 8'hFD), 16));
    tbl16.push_back(ex(enc(2, 3, 1, 2), 20));
    tbl16.push_back(ex(enc(3, 4, 1, 2), 24));
    tbl16.push_back(sw(enc(11, 0, 3, 0), 0, 24, 16'h00, 16'h0002));
    tbl16.push_back(rel(28, 0));
    tbl16.push_back(sw(enc(11, 0, 4, 1), 0, 28, 16'h01, 16'h0008));
    tbl16.push_back(rel(32, 0));
    tbl16.push_back(ld(enc(9, 9, 0, 8'h90), 1, 32, 16'hFF90));
    tbl16.push_back(rel(36, 16'hBEEF));
    tbl16.push_back(sw(enc(11, 0, 9, 2), 0, 36, 16'h02, 16'hBEEF));
    tbl16.push_back(rel(40, 0));

    @(posedge CLK);
    #1;
    foreach (tbl8[i]) run(tbl8[i], 1'b0, "w8", i);

    // reset during an outstanding load: load data must be dropped
    run(rs(), 1'b0, "rst_ld", 0);
    run(ex(enc(0, 5, 0, 8'h66), 4), 1'b0, "rst_ld", 1);
    run(ex(enc(0, 1, 0, 8'h30), 8), 1'b0, "rst_ld", 2);
    run(ld(enc(8, 5, 0, 1), 1, 8, 16'h30), 1'b0, "rst_ld", 3);
    run(hold(8, 1, 0, 16'h30), 1'b0, "rst_ld", 4);
    run(mk(1, NOP_I, 0, 0, 16'h55, 0, 0, 0, 1, 0, 1, 0),
        1'b0, "rst_ld", 5);
    run(sw(enc(11, 0, 5, 0), 0, 0, 16'h00, 16'h00), 1'b0, "rst_ld", 6);
    run(rel(4, 0), 1'b0, "rst_ld", 7);
    run(sw(enc(11, 0, 1, 0), 0, 4, 16'h00, 16'h00), 1'b0, "rst_ld", 8);
    run(rel(8, 0), 1'b0, "rst_ld", 9);

    foreach (tbl16[i]) run(tbl16[i], 1'b1, "w16", i);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
